// File: rtl/vx_bank_flush_pkg.sv
// Shared definitions for the per-bank flush sequencer: FSM state encoding
// and the default select widths derived from the default bank geometry.
package vx_bank_flush_pkg;

  localparam int unsigned DEF_NUM_SETS = 64;
  localparam int unsigned DEF_NUM_WAYS = 4;

  localparam int unsigned LINE_SEL_BITS = $clog2(DEF_NUM_SETS);
  localparam int unsigned WAY_SEL_BITS  = $clog2(DEF_NUM_WAYS);

  typedef enum logic [2:0] {
    FLUSH_STATE_INIT  = 3'd0,
    FLUSH_STATE_IDLE  = 3'd1,
    FLUSH_STATE_WAIT1 = 3'd2,
    FLUSH_STATE_FLUSH = 3'd3,
    FLUSH_STATE_WAIT2 = 3'd4,
    FLUSH_STATE_DONE  = 3'd5
  } flush_state_e;

endpackage

// File: rtl/vx_bank_flush_counter.sv
// Step counter for the flush walk: synchronous clear (priority over
// enable), enable-gated increment, and a terminal-count flag against a
// caller-supplied final value.
module vx_bank_flush_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc_c
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise advance only when enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc_c  = (count_q == max_val);

endmodule

// File: rtl/vx_bank_flush.sv
// Per-bank flush sequencer. Accepts a flush_begin pulse, waits for the bank
// to drain, walks every line (or every line/way in write-back mode) issuing
// flush requests, waits for the writebacks to drain and pulses flush_end.
// Define BANK_FLUSH_INIT_EN to add the post-reset tag-invalidation walk.
module vx_bank_flush
  import vx_bank_flush_pkg::*;
#(
  parameter int unsigned NUM_SETS  = DEF_NUM_SETS,
  parameter int unsigned NUM_WAYS  = DEF_NUM_WAYS,
  parameter bit          WRITEBACK = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush_begin,
  output logic                        flush_end,
  input  logic                        bank_empty,
  output logic                        flush_valid,
  input  logic                        flush_ready,
  output logic                        flush_init,
  output logic [$clog2(NUM_SETS)-1:0] flush_line,
  output logic [NUM_WAYS-1:0]         flush_way
);

  localparam int unsigned LINE_W    = $clog2(NUM_SETS);
  localparam int unsigned WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned WAY_SHIFT = $clog2(NUM_WAYS);
  localparam int unsigned CNT_W     = $clog2(NUM_SETS * NUM_WAYS);
  localparam int unsigned STEPS     = WRITEBACK ? (NUM_SETS * NUM_WAYS) : NUM_SETS;

`ifdef BANK_FLUSH_INIT_EN
  localparam flush_state_e RESET_STATE = FLUSH_STATE_INIT;
`else
  localparam flush_state_e RESET_STATE = FLUSH_STATE_IDLE;
`endif

  flush_state_e     state_q, state_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_max_c;
  logic             cnt_clr_c;
  logic             cnt_tc_c;
  logic             fire_c;
  logic [WAY_W-1:0] way_idx_c;

  assign fire_c    = flush_valid & flush_ready;
  assign way_idx_c = WAY_W'(cnt & CNT_W'(NUM_WAYS - 1));

  vx_bank_flush_counter #(
    .WIDTH (CNT_W)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr_c),
    .en      (fire_c),
    .max_val (cnt_max_c),
    .count   (cnt),
    .tc_c    (cnt_tc_c)
  );

  // State and sticky pending-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Next state, pending bookkeeping and counter control.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_clr_c = 1'b0;
    cnt_max_c = CNT_W'(STEPS - 1);

    // Requests arriving while busy collapse into a single pending flush.
    if (flush_begin && (state_q != FLUSH_STATE_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
`ifdef BANK_FLUSH_INIT_EN
      FLUSH_STATE_INIT: begin
        cnt_max_c = CNT_W'(NUM_SETS - 1);
        if (fire_c && cnt_tc_c) begin
          state_d   = FLUSH_STATE_IDLE;
          cnt_clr_c = 1'b1;
        end
      end
`endif
      FLUSH_STATE_IDLE: begin
        if (flush_begin || pending_q) begin
          state_d   = FLUSH_STATE_WAIT1;
          pending_d = 1'b0;
        end
      end
      FLUSH_STATE_WAIT1: begin
        if (bank_empty) begin
          state_d   = FLUSH_STATE_FLUSH;
          cnt_clr_c = 1'b1;
        end
      end
      FLUSH_STATE_FLUSH: begin
        if (fire_c && cnt_tc_c) begin
          state_d   = FLUSH_STATE_WAIT2;
          cnt_clr_c = 1'b1;
        end
      end
      FLUSH_STATE_WAIT2: begin
        if (bank_empty) begin
          state_d = FLUSH_STATE_DONE;
        end
      end
      FLUSH_STATE_DONE: begin
        state_d = FLUSH_STATE_IDLE;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Output decode from registered state and step counter only.
  always_comb begin
    flush_valid = 1'b0;
    flush_init  = 1'b0;
    flush_end   = 1'b0;
    flush_line  = LINE_W'(cnt);
    flush_way   = '1;

    case (state_q)
`ifdef BANK_FLUSH_INIT_EN
      FLUSH_STATE_INIT: begin
        flush_valid = 1'b1;
        flush_init  = 1'b1;
      end
`endif
      FLUSH_STATE_FLUSH: begin
        flush_valid = 1'b1;
        if (WRITEBACK) begin
          // Ways advance first: low counter bits pick the way, high bits the set.
          flush_line = LINE_W'(cnt >> WAY_SHIFT);
          flush_way  = NUM_WAYS'(1) << way_idx_c;
        end
      end
      FLUSH_STATE_DONE: begin
        flush_end = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_vx_bank_flush.sv
// Bench for vx_bank_flush: a write-through instance (64x4) and a write-back
// instance (16x4) run side by side against a phase-level reference model,
// with directed latency/ordering scenarios followed by random traffic.
// Honours BANK_FLUSH_INIT_EN the same way the design does.
module tb_vx_bank_flush;
  import vx_bank_flush_pkg::*;

  localparam int unsigned S0 = DEF_NUM_SETS;
  localparam int unsigned W0 = DEF_NUM_WAYS;
  localparam int unsigned S1 = 16;
  localparam int unsigned W1 = 4;
`ifdef BANK_FLUSH_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  localparam int M_INIT = 0, M_IDLE = 1, M_DRAIN1 = 2, M_WALK = 3, M_DRAIN2 = 4, M_DONE = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fb[2], be[2], rdy[2];
  logic fe[2], fv[2], fi[2];
  logic [LINE_SEL_BITS-1:0] line0;
  logic [W0-1:0]            way0;
  logic [$clog2(S1)-1:0]    line1;
  logic [W1-1:0]            way1;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Reference model state.
  int          ph[2];
  int unsigned stp[2];
  bit          pend[2];
  bit          model_on = 1'b0;
  int unsigned nfire[2], nend[2];
  logic [31:0] cap_line, cap_way;

  // Stimulus helpers.
  int mode = 0;
  bit tgl;
  int nvalid;

  always #5 clk = ~clk;

  vx_bank_flush #(.NUM_SETS(S0), .NUM_WAYS(W0), .WRITEBACK(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .flush_begin(fb[0]), .flush_end(fe[0]),
    .bank_empty(be[0]), .flush_valid(fv[0]), .flush_ready(rdy[0]),
    .flush_init(fi[0]), .flush_line(line0), .flush_way(way0)
  );

  vx_bank_flush #(.NUM_SETS(S1), .NUM_WAYS(W1), .WRITEBACK(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .flush_begin(fb[1]), .flush_end(fe[1]),
    .bank_empty(be[1]), .flush_valid(fv[1]), .flush_ready(rdy[1]),
    .flush_init(fi[1]), .flush_line(line1), .flush_way(way1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Per-cycle reference check and model advance, away from the active edge.
  int unsigned sets, ways, nsteps;
  bit          wb, ev;
  logic [31:0] el, ew, gl, gw;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      sets   = (d == 0) ? S0 : S1;
      ways   = (d == 0) ? W0 : W1;
      wb     = (d == 1);
      nsteps = wb ? sets * ways : sets;
      ev     = (ph[d] == M_INIT) || (ph[d] == M_WALK);
      el     = (ph[d] == M_WALK && wb) ? stp[d] / ways : stp[d];
      ew     = (ph[d] == M_WALK && wb) ? (32'd1 << (stp[d] % ways)) : 32'hF;
      gl     = (d == 0) ? 32'(line0) : 32'(line1);
      gw     = (d == 0) ? 32'(way0) : 32'(way1);
      if (model_on) begin
        check_eq($sformatf("d%0d_valid", d), 32'(fv[d]), 32'(ev));
        check_eq($sformatf("d%0d_init", d), 32'(fi[d]), 32'(ph[d] == M_INIT));
        check_eq($sformatf("d%0d_end", d), 32'(fe[d]), 32'(ph[d] == M_DONE));
        check_eq($sformatf("d%0d_line", d), gl, el);
        check_eq($sformatf("d%0d_way", d), gw, ew);
        if (!reset) begin
          if (ev && rdy[d]) nfire[d]++;
          if (fe[d]) nend[d]++;
          if (d == 1 && ph[d] == M_WALK && stp[d] == 5) begin
            cap_line = gl;
            cap_way  = gw;
          end
        end
      end
      if (reset) begin
        ph[d]   = INIT_EN ? M_INIT : M_IDLE;
        stp[d]  = 0;
        pend[d] = 1'b0;
      end else begin
        if (fb[d] && ph[d] != M_IDLE) pend[d] = 1'b1;
        case (ph[d])
          M_INIT:   if (rdy[d]) begin
                      if (stp[d] == sets - 1) begin ph[d] = M_IDLE; stp[d] = 0; end
                      else stp[d]++;
                    end
          M_IDLE:   if (fb[d] || pend[d]) begin ph[d] = M_DRAIN1; pend[d] = 1'b0; end
          M_DRAIN1: if (be[d]) begin ph[d] = M_WALK; stp[d] = 0; end
          M_WALK:   if (rdy[d]) begin
                      if (stp[d] == nsteps - 1) begin ph[d] = M_DRAIN2; stp[d] = 0; end
                      else stp[d]++;
                    end
          M_DRAIN2: if (be[d]) ph[d] = M_DONE;
          default:  ph[d] = M_IDLE;
        endcase
      end
    end
    if (reset) model_on = 1'b1;
  end

  // Pulse flush_begin on DUT d and watch flush_end for max_cyc cycles.
  task automatic run_flush(input int d, input int max_cyc,
                           output int first_end, output int last_end, output int ends);
    first_end = -1;
    last_end  = -1;
    ends      = 0;
    nvalid    = 0;
    tgl       = 1'b0;
    fb[d]     = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      tick;
      fb[d] = 1'b0;
      case (mode)
        1: begin
          rdy[d] = fv[d] ? tgl : 1'b1;
          if (fv[d]) begin tgl = ~tgl; nvalid++; end
        end
        2: begin
          be[d] = !((c >= 1 && c <= 10) || (c >= 76 && c <= 82));
          if (c <= 11 && fv[d]) nvalid++;
        end
        3: fb[d] = (c == 10 || c == 20 || c == 30 || c == 67);
        default: ;
      endcase
      if (fe[d]) begin
        if (first_end < 0) first_end = c;
        last_end = c;
        ends++;
      end
    end
    mode   = 0;
    rdy[d] = 1'b1;
    be[d]  = 1'b1;
    fb[d]  = 1'b0;
  endtask

  initial begin
    int fe1, fel, nends, icnt0, icnt1;
    bit found;
    fb = '{1'b0, 1'b0};
    be = '{1'b1, 1'b1};
    rdy = '{1'b1, 1'b1};
    reset = 1'b1;
    tick;
    tick;
    // Reset state, then the optional invalidation walk.
    check_eq("rst_end0", 32'(fe[0]), 32'd0);
    check_eq("rst_valid0", 32'(fv[0]), 32'(INIT_EN));
    check_eq("rst_line0", 32'(line0), 32'd0);
    reset = 1'b0;
    nend = '{0, 0};
    icnt0 = 0;
    icnt1 = 0;
    for (int c = 0; c < 100; c++) begin
      if (fi[0]) icnt0++;
      if (fi[1]) icnt1++;
      tick;
    end
    check_eq("init_cycles0", 32'(icnt0), INIT_EN ? S0 : 32'd0);
    check_eq("init_cycles1", 32'(icnt1), INIT_EN ? S1 : 32'd0);
    check_eq("init_no_end", nend[0] + nend[1], 32'd0);

    // Single write-through flush, minimum latency.
    nfire = '{0, 0};
    run_flush(0, 80, fe1, fel, nends);
    check_eq("wt_latency", 32'(fe1), S0 + 3);
    check_eq("wt_end_count", 32'(nends), 32'd1);
    check_eq("wt_fires", nfire[0], S0);

    // Single write-back flush: every line/way, ways first.
    nfire = '{0, 0};
    cap_line = '1;
    cap_way = '1;
    run_flush(1, 80, fe1, fel, nends);
    check_eq("wb_latency", 32'(fe1), S1 * W1 + 3);
    check_eq("wb_end_count", 32'(nends), 32'd1);
    check_eq("wb_fires", nfire[1], S1 * W1);
    check_eq("wb_step5_line", cap_line, 32'd1);
    check_eq("wb_step5_way", cap_way, 32'b0010);

    // Ready toggling during the walk.
    nfire = '{0, 0};
    mode = 1;
    run_flush(0, 140, fe1, fel, nends);
    check_eq("tgl_valid_cycles", 32'(nvalid), 2 * S0);
    check_eq("tgl_latency", 32'(fe1), 2 * S0 + 3);
    check_eq("tgl_fires", nfire[0], S0);

    // Bank not empty for 10 cycles before and 7 cycles after the walk.
    mode = 2;
    run_flush(0, 100, fe1, fel, nends);
    check_eq("drain_no_early_valid", 32'(nvalid), 32'd0);
    check_eq("drain_latency", 32'(fe1), S0 + 3 + 17);
    check_eq("drain_end_count", 32'(nends), 32'd1);

    // Extra pulses while busy collapse into exactly one more flush.
    nfire = '{0, 0};
    mode = 3;
    run_flush(0, 200, fe1, fel, nends);
    check_eq("pend_first_end", 32'(fe1), S0 + 3);
    check_eq("pend_last_end", 32'(fel), 2 * S0 + 7);
    check_eq("pend_end_count", 32'(nends), 32'd2);
    check_eq("pend_fires", nfire[0], 2 * S0);

    // Reset in the middle of a walk with a pending request outstanding.
    found = 1'b0;
    fb[0] = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      tick;
      fb[0] = (c == 4);
      if (fv[0] && !fi[0] && line0 == LINE_SEL_BITS'(20)) found = 1'b1;
    end
    fb[0] = 1'b0;
    check_eq("rstmid_reach_line20", 32'(found), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_eq("rstmid_line", 32'(line0), 32'd0);
    check_eq("rstmid_init", 32'(fi[0]), 32'(INIT_EN));
    nend = '{0, 0};
    repeat (150) tick;
    check_eq("rstmid_no_end0", nend[0], 32'd0);
    check_eq("rstmid_no_end1", nend[1], 32'd0);

    // Random traffic on both banks against the reference model.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 2; d++) begin
        fb[d]  = ($urandom_range(39) == 0);
        be[d]  = ($urandom_range(3) != 0);
        rdy[d] = ($urandom_range(4) < 3);
      end
      reset = ($urandom_range(599) == 0);
      tick;
    end
    reset = 1'b0;
    fb = '{1'b0, 1'b0};
    be = '{1'b1, 1'b1};
    rdy = '{1'b1, 1'b1};
    repeat (300) tick;
    check_eq("rand_settle_idle0", 32'(fv[0]), 32'd0);
    check_eq("rand_settle_idle1", 32'(fv[1]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
